// File: rtl/branch_rs_if.sv
// Dispatch, result-broadcast and issue signals of the branch reservation station.
// The slave side belongs to the station; the master side to its environment.
interface branch_rs_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OP_W   = 6
);
    logic              disEn;
    logic [OP_W-1:0]   disOp;
    logic [DATA_W-1:0] disImm;
    logic [ADDR_W-1:0] disPC;
    logic [1:0]        disBNum;
    logic              disPred;
    logic [TAG_W-1:0]  disTagO;
    logic [TAG_W-1:0]  disTagT;
    logic [DATA_W-1:0] disValO;
    logic [DATA_W-1:0] disValT;
    logic              aluCdbEn;
    logic [TAG_W-1:0]  aluCdbTag;
    logic [DATA_W-1:0] aluCdbData;
    logic              lsCdbEn;
    logic [TAG_W-1:0]  lsCdbTag;
    logic [DATA_W-1:0] lsCdbData;
    logic              flush;
    logic              rsFull;
    logic              BranchWorkEn;
    logic [DATA_W-1:0] operandO;
    logic [DATA_W-1:0] operandT;
    logic [OP_W-1:0]   opCode;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] PC;
    logic [1:0]        bNum;
    logic              pred;

    modport slave (
        input  disEn, disOp, disImm, disPC, disBNum, disPred,
               disTagO, disTagT, disValO, disValT,
               aluCdbEn, aluCdbTag, aluCdbData,
               lsCdbEn, lsCdbTag, lsCdbData, flush,
        output rsFull, BranchWorkEn, operandO, operandT, opCode, imm, PC, bNum, pred
    );

    modport master (
        output disEn, disOp, disImm, disPC, disBNum, disPred,
               disTagO, disTagT, disValO, disValT,
               aluCdbEn, aluCdbTag, aluCdbData,
               lsCdbEn, lsCdbTag, lsCdbData, flush,
        input  rsFull, BranchWorkEn, operandO, operandT, opCode, imm, PC, bNum, pred
    );
endinterface

// File: rtl/branch_rs.sv
// Branch reservation station: buffers dispatched branches, wakes operands from the
// ALU and load/store result buses, and issues the lowest-index ready entry per cycle.
module branch_rs #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int OP_W    = 6
) (
    input  logic         clk,
    input  logic         rst,
    branch_rs_if.slave   bus
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] pc;
        logic [1:0]        bnum;
        logic              pred;
        logic [TAG_W-1:0]  tag_o;
        logic [DATA_W-1:0] val_o;
        logic [TAG_W-1:0]  tag_t;
        logic [DATA_W-1:0] val_t;
    } entry_t;

    typedef struct packed {
        logic              work_en;
        logic [DATA_W-1:0] operand_o;
        logic [DATA_W-1:0] operand_t;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] pc;
        logic [1:0]        bnum;
        logic              pred;
    } issue_t;

    entry_t           ent_q [ENTRIES];
    entry_t           ent_d [ENTRIES];
    issue_t           iss_q;
    issue_t           iss_d;
    logic             rs_full;
    logic             iss_found;
    logic             disp_found;
    logic [IDX_W-1:0] iss_idx;
    logic [IDX_W-1:0] disp_idx;

    // Returns {tag, value}; a pending tag matching a broadcast resolves to tag 0, ALU first.
    function automatic logic [TAG_W+DATA_W-1:0] snoop(
        input logic [TAG_W-1:0]  tag,
        input logic [DATA_W-1:0] val,
        input logic              alu_en,
        input logic [TAG_W-1:0]  alu_tag,
        input logic [DATA_W-1:0] alu_data,
        input logic              ls_en,
        input logic [TAG_W-1:0]  ls_tag,
        input logic [DATA_W-1:0] ls_data
    );
        snoop = {tag, val};
        if (tag != '0) begin
            if (alu_en && (tag == alu_tag)) begin
                snoop = {{TAG_W{1'b0}}, alu_data};
            end else if (ls_en && (tag == ls_tag)) begin
                snoop = {{TAG_W{1'b0}}, ls_data};
            end
        end
    endfunction

    always_comb begin
        ent_d         = ent_q;
        iss_d         = iss_q;
        iss_d.work_en = 1'b0;
        rs_full       = 1'b1;
        iss_found     = 1'b0;
        iss_idx       = '0;
        disp_found    = 1'b0;
        disp_idx      = '0;

        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!ent_q[i].valid) begin
                rs_full = 1'b0;
            end
            if (!iss_found && ent_q[i].valid && (ent_q[i].tag_o == '0) && (ent_q[i].tag_t == '0)) begin
                iss_found = 1'b1;
                iss_idx   = IDX_W'(i);
            end
            if (!disp_found && !ent_q[i].valid) begin
                disp_found = 1'b1;
                disp_idx   = IDX_W'(i);
            end
        end

        if (iss_found) begin
            iss_d.work_en   = 1'b1;
            iss_d.operand_o = ent_q[iss_idx].val_o;
            iss_d.operand_t = ent_q[iss_idx].val_t;
            iss_d.op        = ent_q[iss_idx].op;
            iss_d.imm       = ent_q[iss_idx].imm;
            iss_d.pc        = ent_q[iss_idx].pc;
            iss_d.bnum      = ent_q[iss_idx].bnum;
            iss_d.pred      = ent_q[iss_idx].pred;
            ent_d[iss_idx].valid = 1'b0;
        end

        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (ent_q[i].valid) begin
                {ent_d[i].tag_o, ent_d[i].val_o} = snoop(ent_q[i].tag_o, ent_q[i].val_o,
                    bus.aluCdbEn, bus.aluCdbTag, bus.aluCdbData, bus.lsCdbEn, bus.lsCdbTag, bus.lsCdbData);
                {ent_d[i].tag_t, ent_d[i].val_t} = snoop(ent_q[i].tag_t, ent_q[i].val_t,
                    bus.aluCdbEn, bus.aluCdbTag, bus.aluCdbData, bus.lsCdbEn, bus.lsCdbTag, bus.lsCdbData);
            end
        end

        // The slot chosen from the pre-edge valid bits is never the one issuing this edge.
        if (bus.disEn && disp_found) begin
            ent_d[disp_idx].valid = 1'b1;
            ent_d[disp_idx].op    = bus.disOp;
            ent_d[disp_idx].imm   = bus.disImm;
            ent_d[disp_idx].pc    = bus.disPC;
            ent_d[disp_idx].bnum  = bus.disBNum;
            ent_d[disp_idx].pred  = bus.disPred;
            {ent_d[disp_idx].tag_o, ent_d[disp_idx].val_o} = snoop(bus.disTagO, bus.disValO,
                bus.aluCdbEn, bus.aluCdbTag, bus.aluCdbData, bus.lsCdbEn, bus.lsCdbTag, bus.lsCdbData);
            {ent_d[disp_idx].tag_t, ent_d[disp_idx].val_t} = snoop(bus.disTagT, bus.disValT,
                bus.aluCdbEn, bus.aluCdbTag, bus.aluCdbData, bus.lsCdbEn, bus.lsCdbTag, bus.lsCdbData);
        end

        if (bus.flush) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ent_d[i].valid = 1'b0;
            end
            iss_d         = iss_q;
            iss_d.work_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            iss_q <= '0;
        end else begin
            ent_q <= ent_d;
            iss_q <= iss_d;
        end
    end

    assign bus.rsFull       = rs_full;
    assign bus.BranchWorkEn = iss_q.work_en;
    assign bus.operandO     = iss_q.operand_o;
    assign bus.operandT     = iss_q.operand_t;
    assign bus.opCode       = iss_q.op;
    assign bus.imm          = iss_q.imm;
    assign bus.PC           = iss_q.pc;
    assign bus.bNum         = iss_q.bnum;
    assign bus.pred         = iss_q.pred;
endmodule

// File: tb/tb_branch_rs.sv
// Scoreboard bench for branch_rs: a slot-level reference model queues expected issues,
// an independent monitor checks every cycle's outputs against them.
module tb_branch_rs;
    localparam int ENTRIES = 4;
    localparam int TAG_W   = 4;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int OP_W    = 6;
    localparam int PW      = 3 * DATA_W + ADDR_W + OP_W + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    branch_rs_if #(.TAG_W(TAG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) bus ();

    branch_rs #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                valid;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] pc;
        logic [1:0]        bnum;
        logic              pred;
        int                tag_o;
        logic [DATA_W-1:0] val_o;
        int                tag_t;
        logic [DATA_W-1:0] val_t;
    } slot_t;

    typedef struct {
        int            cycle;
        logic [PW-1:0] f;
    } exp_t;

    slot_t         m [ENTRIES];
    exp_t          expq [$];
    logic [PW-1:0] last = '0;
    bit            m_full = 1'b0;
    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;

    // A pending tag takes the value of whichever bus names it, ALU preferred.
    function automatic void resolve(inout int tag, inout logic [DATA_W-1:0] val);
        if (tag != 0) begin
            if (bus.aluCdbEn && tag == int'(bus.aluCdbTag)) begin
                val = bus.aluCdbData; tag = 0;
            end else if (bus.lsCdbEn && tag == int'(bus.lsCdbTag)) begin
                val = bus.lsCdbData; tag = 0;
            end
        end
    endfunction

    always @(posedge clk) begin : model
        int   di;
        int   ii;
        exp_t e;
        cyc++;
        if (!rst) begin
            foreach (m[i]) m[i].valid = 1'b0;
            last = '0;
        end else if (bus.flush) begin
            foreach (m[i]) m[i].valid = 1'b0;
        end else begin
            di = -1;
            ii = -1;
            foreach (m[i]) begin
                if (di < 0 && !m[i].valid) di = i;
                if (ii < 0 && m[i].valid && m[i].tag_o == 0 && m[i].tag_t == 0) ii = i;
            end
            if (ii >= 0) begin
                e.cycle = cyc;
                e.f = {m[ii].val_o, m[ii].val_t, m[ii].op, m[ii].imm, m[ii].pc, m[ii].bnum, m[ii].pred};
                expq.push_back(e);
                last = e.f;
                m[ii].valid = 1'b0;
            end
            foreach (m[i]) begin
                if (m[i].valid) begin
                    resolve(m[i].tag_o, m[i].val_o);
                    resolve(m[i].tag_t, m[i].val_t);
                end
            end
            if (bus.disEn && di >= 0) begin
                m[di].valid = 1'b1;
                m[di].op    = bus.disOp;
                m[di].imm   = bus.disImm;
                m[di].pc    = bus.disPC;
                m[di].bnum  = bus.disBNum;
                m[di].pred  = bus.disPred;
                m[di].tag_o = int'(bus.disTagO);
                m[di].val_o = bus.disValO;
                m[di].tag_t = int'(bus.disTagT);
                m[di].val_t = bus.disValT;
                resolve(m[di].tag_o, m[di].val_o);
                resolve(m[di].tag_t, m[di].val_t);
            end
        end
        m_full = 1'b1;
        foreach (m[i]) if (!m[i].valid) m_full = 1'b0;
    end

    always @(negedge clk) begin : monitor
        logic [PW-1:0] act;
        exp_t          e;
        act = {bus.operandO, bus.operandT, bus.opCode, bus.imm, bus.PC, bus.bNum, bus.pred};
        n_vec++;
        if (bus.rsFull !== m_full) begin
            n_err++;
            $display("FAIL rsFull cyc=%0d got=%b exp=%b", cyc, bus.rsFull, m_full);
        end
        n_vec++;
        if (bus.BranchWorkEn === 1'b1) begin
            if (expq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_issue cyc=%0d got=%h exp=none", cyc, act);
            end else begin
                e = expq.pop_front();
                if (e.cycle != cyc || act !== e.f) begin
                    n_err++;
                    $display("FAIL issue cyc=%0d got=%h exp_cyc=%0d exp=%h", cyc, act, e.cycle, e.f);
                end
            end
        end else if (bus.BranchWorkEn !== 1'b0) begin
            n_err++;
            $display("FAIL work_en_unknown cyc=%0d got=%b exp=0/1", cyc, bus.BranchWorkEn);
        end else if (expq.size() != 0 && expq[0].cycle <= cyc) begin
            e = expq.pop_front();
            n_err++;
            $display("FAIL missing_issue cyc=%0d got=none exp=%h", cyc, e.f);
        end else if (act !== last) begin
            n_err++;
            $display("FAIL held_outputs cyc=%0d got=%h exp=%h", cyc, act, last);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
        bus.disEn    = 1'b0;
        bus.aluCdbEn = 1'b0;
        bus.lsCdbEn  = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_disp(input int op, input int to, input logic [31:0] vo, input int tt,
                            input logic [31:0] vt, input logic [31:0] pc, input logic [31:0] im,
                            input int bn, input int pr);
        bus.disEn   = 1'b1;
        bus.disOp   = OP_W'(op);
        bus.disTagO = TAG_W'(to);
        bus.disValO = vo;
        bus.disTagT = TAG_W'(tt);
        bus.disValT = vt;
        bus.disPC   = pc;
        bus.disImm  = im;
        bus.disBNum = 2'(bn);
        bus.disPred = pr[0];
    endtask

    task automatic set_cdb(input bit ae, input int at, input logic [31:0] ad,
                           input bit le, input int lt, input logic [31:0] ld);
        bus.aluCdbEn   = ae;
        bus.aluCdbTag  = TAG_W'(at);
        bus.aluCdbData = ad;
        bus.lsCdbEn    = le;
        bus.lsCdbTag   = TAG_W'(lt);
        bus.lsCdbData  = ld;
    endtask

    function automatic int rtag();
        return ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 5));
    endfunction

    initial begin : stim
        set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_cdb(0, 0, 0, 0, 0, 0);
        bus.disEn = 1'b0;
        bus.flush = 1'b0;
        rst = 1'b0;
        idle(2);
        n_vec++;
        if (bus.BranchWorkEn !== 1'b0 || bus.rsFull !== 1'b0 || bus.operandO !== '0 ||
            bus.operandT !== '0 || bus.opCode !== '0 || bus.imm !== '0 || bus.PC !== '0 ||
            bus.bNum !== '0 || bus.pred !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got=en%b full%b o%h t%h pc%h exp=all zero",
                     bus.BranchWorkEn, bus.rsFull, bus.operandO, bus.operandT, bus.PC);
        end
        rst = 1'b1;
        step();

        // Ready dispatch: issue two edges after dispatch.
        set_disp(0, 0, 5, 0, 5, 32'h100, 8, 1, 1); step(); idle(3);

        // Wakeup via ALU, via LS, and both buses with the same tag.
        set_disp(1, 3, 0, 0, 7, 32'h200, 16, 2, 0); step(); idle(2);
        set_cdb(1, 3, 9, 0, 0, 0); step(); idle(2);
        set_disp(1, 3, 0, 0, 7, 32'h204, 16, 2, 0); step(); idle(2);
        set_cdb(0, 0, 0, 1, 3, 11); step(); idle(2);
        set_disp(1, 3, 0, 0, 7, 32'h208, 16, 2, 0); step(); idle(2);
        set_cdb(1, 3, 9, 1, 3, 32'hAAAA); step(); idle(2);

        // Dispatch bypass from the LS bus.
        set_disp(2, 0, 1, 2, 0, 32'h300, 4, 3, 1);
        set_cdb(0, 0, 0, 1, 2, 32'hFFFF_FFFF); step(); idle(3);

        // Fill, ignored 5th dispatch, then entries 3 and 1 woken together.
        set_disp(3, 4, 0, 0, 1, 32'h400, 0, 0, 0); step();
        set_disp(3, 5, 0, 0, 2, 32'h404, 0, 1, 0); step();
        set_disp(3, 6, 0, 0, 3, 32'h408, 0, 2, 0); step();
        set_disp(3, 7, 0, 0, 4, 32'h40C, 0, 3, 0); step();
        set_disp(3, 0, 0, 0, 5, 32'h410, 0, 0, 1); step();
        set_cdb(1, 7, 70, 1, 5, 50); step(); idle(3);
        bus.flush = 1'b1; step(); idle(1);

        // Flush with 3 valid entries (one ready) and a simultaneous dispatch.
        set_disp(4, 8, 0, 0, 1, 32'h500, 0, 0, 0); step();
        set_disp(4, 9, 0, 0, 2, 32'h504, 0, 1, 0); step();
        set_disp(4, 0, 3, 0, 3, 32'h508, 0, 2, 1); step();
        set_disp(4, 0, 6, 0, 6, 32'h50C, 0, 3, 1);
        bus.flush = 1'b1; step(); idle(1);
        set_cdb(1, 8, 80, 1, 9, 90); step(); idle(3);

        // Randomized traffic with occasional flush and mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 1) == 1)
                set_disp(int'($urandom_range(0, 63)), rtag(), $urandom, rtag(), $urandom,
                         $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            set_cdb($urandom_range(0, 1) == 1, int'($urandom_range(1, 5)), $urandom,
                    $urandom_range(0, 1) == 1, int'($urandom_range(1, 5)), $urandom);
            bus.flush = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b1;
        idle(5);

        n_vec++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected got=%0d exp=0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/branch_rs.md
Name: branch_rs

Overview:
- Reservation station for conditional branches; sits directly upstream of the branch execute unit.
- Buffers dispatched branch instructions and wakes up their source operands by snooping two result broadcast buses.
- Each cycle, issues one fully-ready entry (opcode, operands, imm, PC, bNum, pred) to the branch unit through registered outputs.
- Clears all entries on a mispredict flush.

Parameters:
- ENTRIES, 4, number of RS slots (≥2)
- TAG_W, 4, rename tag width; tag value 0 means "operand already valid"
- DATA_W, 32, operand/imm width
- ADDR_W, 32, instruction address width
- OP_W, 6, internal opcode width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- disEn  in  1  dispatch a new branch this cycle
- disOp  in  OP_W  branch opcode (BEQ/BNE/BLT/BGE/BLTU/BGEU encoding)
- disImm  in  DATA_W  sign-extended offset
- disPC  in  ADDR_W  branch PC
- disBNum  in  2  branch-checkpoint number
- disPred  in  1  predicted taken
- disTagO / disTagT  in  TAG_W  source tags (0 = value valid)
- disValO / disValT  in  DATA_W  source values (used when tag = 0)
- aluCdbEn, aluCdbTag[TAG_W], aluCdbData[DATA_W]  in  ALU broadcast
- lsCdbEn, lsCdbTag[TAG_W], lsCdbData[DATA_W]  in  load/store broadcast
- flush  in  1  mispredict flush (driven from misTaken)
- rsFull  out  1  all entries valid
- BranchWorkEn  out  1  issue strobe to branch unit
- operandO, operandT  out  DATA_W  issued operands
- opCode  out  OP_W
- imm  out  DATA_W
- PC  out  ADDR_W
- bNum  out  2
- pred  out  1

Behaviour:
- Per entry state: valid, op, imm, PC, bNum, pred, tagO/valO, tagT/valT.
- Entry ready = valid && tagO==0 && tagT==0, evaluated on registered state.
- Reset (rst=0 at posedge): all valid=0; all outputs 0.
- Reset mid-operation: drops all entries; nothing issues the following cycle.

Dispatch:
- disEn=1 and not rsFull: write into the lowest-index invalid entry at posedge.
- disEn while rsFull: ignored (the dispatcher must not do this).
- rsFull is computed from current valid bits only. An issue in the same cycle does not make room until the next cycle.

Wakeup:
- Each cycle, for every valid entry and each operand with tag≠0: if aluCdbEn && tag==aluCdbTag, capture aluCdbData and set tag=0. Otherwise the same check applies against the LS bus.
- If both buses carry the same tag, ALU wins.
- Bypass at dispatch: a dispatched tag matching a CDB in the same cycle is stored as tag=0 with the CDB value.

Issue:
- Select the lowest-index ready entry. At posedge, register its fields onto the outputs, set BranchWorkEn=1, and clear that entry's valid.
- No ready entry: BranchWorkEn=0 and the other outputs hold their last values.

Latency and width rules:
- Dispatch with ready operands → earliest BranchWorkEn is 2 cycles later (write edge, then issue edge).
- CDB wakeup edge → earliest issue on the next edge.
- An entry never issues on the same edge it is written or woken.
- One issue per cycle max; no width conversion, all fields are copied verbatim.

Flush:
- flush=1 at posedge: clears all valid bits and forces BranchWorkEn=0.
- flush has priority over dispatch, wakeup and issue in that cycle.
- The next cycle accepts dispatch normally.

Test Plan:
- Reset: hold rst=0 two cycles, then release → BranchWorkEn=0, rsFull=0, all outputs 0.
- Ready dispatch: BEQ, tags 0, valO=valT=5, PC=0x100, imm=8, pred=1 at cycle 0 → cycle 2 BranchWorkEn=1, operandO=operandT=5, PC=0x100, imm=8, pred=1; entry freed.
- Wakeup: BNE with tagO=3, valT=7; aluCdb tag 3, data 9 at cycle 4 → issue at cycle 5 with operandO=9, operandT=7. Same case via lsCdb, and both buses with tag 3 → ALU data taken.
- Dispatch bypass: tagT=2 while lsCdb broadcasts tag 2, data 0xFFFFFFFF the same cycle → entry ready; issues 2 cycles after dispatch with operandT=0xFFFFFFFF.
- Full/priority: dispatch 4 entries with unresolved tags → rsFull=1; a 5th disEn is ignored. Wake entries 3 and 1 on the same edge → entry 1 issues, then entry 3 next cycle; rsFull drops after the first issue.
- Flush: 3 valid entries, 1 ready; assert flush together with disEn → next cycle BranchWorkEn=0, rsFull=0, no entries valid; a later CDB broadcast produces no issue.
